// File: rtl/uart_ctrl.sv
// uart_ctrl - bus-side controller for the UART core.
//
// Buffers CPU transmit and receive bytes in two circular FIFOs and runs the
// strobe/acknowledge handshake with the UART core, so the CPU never has to
// touch ss/busy/rec_valid/rr directly. The core's busy and rec_valid are
// generated on its own bit clock and are brought into sclk through 2-flop
// synchronisers before any use.
//
// Register map (addr): 0 TXDATA (W), 1 RXDATA (R, pops), 2 STATUS (R,
// clears the sticky error bits), 3 CTRL (R/W only with UART_CTRL_IRQ_EN).
// STATUS = {0, tx_active, tx_ovf, rx_ovr, rx_full, rx_empty, tx_empty, tx_full}
//
// Optional feature macro: UART_CTRL_IRQ_EN (CTRL register + level irq).
// Without it CTRL reads 0x00 and irq is tied low.
//
// Ports:
//   sclk, reset      system clock; asynchronous active-low reset
//   addr, wdata      register select and write data
//   we, re           single-cycle write / read strobes
//   rdata            registered read data, valid the cycle after re
//   irq              level interrupt
//   u_ss, u_data     send strobe and transmit byte to the core
//   u_busy           core transmit busy (asynchronous)
//   u_rec_data       core received byte
//   u_rec_valid      core receive valid (asynchronous)
//   u_rr             receive-acknowledge pulse to the core
module uart_ctrl #(
   parameter int FIFO_AW = 3
) (
   input  logic       sclk,
   input  logic       reset,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   input  logic       we,
   input  logic       re,
   output logic [7:0] rdata,
   output logic       irq,
   output logic       u_ss,
   output logic [7:0] u_data,
   input  logic       u_busy,
   input  logic [7:0] u_rec_data,
   input  logic       u_rec_valid,
   output logic       u_rr
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
   localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_STATUS = 2'd2, A_CTRL = 2'd3;

   typedef enum logic [2:0] {
      TX_IDLE, TX_SETUP, TX_STROBE1, TX_STROBE2, TX_WAITB, TX_WAITD
   } tx_state_t;
   typedef enum logic [2:0] {
      RX_IDLE, RX_CAPTURE, RX_ACK1, RX_ACK2, RX_WAITL
   } rx_state_t;

   tx_state_t tx_state_reg, tx_state_next;
   rx_state_t rx_state_reg, rx_state_next;

   logic busy_meta_reg, sbusy_reg, valid_meta_reg, svalid_reg;

   logic [7:0]         tx_mem [DEPTH];
   logic [7:0]         rx_mem [DEPTH];
   logic [FIFO_AW-1:0] tx_wptr_reg, tx_rptr_reg, rx_wptr_reg, rx_rptr_reg;
   logic [FIFO_AW:0]   tx_cnt_reg, tx_cnt_next, rx_cnt_reg, rx_cnt_next;
   logic tx_full, tx_empty, rx_full, rx_empty, tx_active;
   logic tx_push, tx_pop, rx_push, rx_pop;
   logic wr_tx, rd_rx, rd_status;
   logic tx_ovf_reg, tx_ovf_next, rx_ovr_reg, rx_ovr_next;
   logic ss_next, rr_next;
   logic [7:0] status, ctrl_rd, rdata_next;

   assign tx_full   = (tx_cnt_reg == FULL_CNT);
   assign tx_empty  = (tx_cnt_reg == '0);
   assign rx_full   = (rx_cnt_reg == FULL_CNT);
   assign rx_empty  = (rx_cnt_reg == '0);
   assign tx_active = (tx_state_reg != TX_IDLE);

   assign wr_tx     = we && (addr == A_TX);
   assign rd_rx     = re && (addr == A_RX);
   assign rd_status = re && (addr == A_STATUS);

   // A push into a full FIFO is accepted only when a pop frees a slot in the
   // same cycle; a pop on an empty FIFO never happens.
   assign tx_push = wr_tx && (!tx_full || tx_pop);
   assign rx_pop  = rd_rx && !rx_empty;
   assign rx_push = (rx_state_reg == RX_CAPTURE) && (!rx_full || rx_pop);

   assign status = {1'b0, tx_active, tx_ovf_reg, rx_ovr_reg,
                    rx_full, rx_empty, tx_empty, tx_full};

   // TX handshake: load, one setup cycle, two strobe cycles, then follow busy.
   always_comb begin
      tx_state_next = tx_state_reg;
      tx_pop        = 1'b0;
      case (tx_state_reg)
         TX_IDLE:    if (!tx_empty) begin
                        tx_pop        = 1'b1;
                        tx_state_next = TX_SETUP;
                     end
         TX_SETUP:   tx_state_next = TX_STROBE1;
         TX_STROBE1: tx_state_next = TX_STROBE2;
         TX_STROBE2: tx_state_next = TX_WAITB;
         TX_WAITB:   if (sbusy_reg) tx_state_next = TX_WAITD;
         TX_WAITD:   if (!sbusy_reg) tx_state_next = TX_IDLE;
         default:    tx_state_next = TX_IDLE;
      endcase
      // Strobe is registered from the next state so it leaves a flop cleanly.
      ss_next = (tx_state_next == TX_STROBE1) || (tx_state_next == TX_STROBE2);
   end

   // RX handshake: capture, two acknowledge cycles, wait for valid to drop.
   always_comb begin
      rx_state_next = rx_state_reg;
      case (rx_state_reg)
         RX_IDLE:    if (svalid_reg) rx_state_next = RX_CAPTURE;
         RX_CAPTURE: rx_state_next = RX_ACK1;
         RX_ACK1:    rx_state_next = RX_ACK2;
         RX_ACK2:    rx_state_next = RX_WAITL;
         RX_WAITL:   if (!svalid_reg) rx_state_next = RX_IDLE;
         default:    rx_state_next = RX_IDLE;
      endcase
      rr_next = (rx_state_next == RX_ACK1) || (rx_state_next == RX_ACK2);
   end

   always_comb begin
      tx_cnt_next = tx_cnt_reg;
      if (tx_push && !tx_pop) tx_cnt_next = tx_cnt_reg + (FIFO_AW+1)'(1);
      else if (!tx_push && tx_pop) tx_cnt_next = tx_cnt_reg - (FIFO_AW+1)'(1);
      rx_cnt_next = rx_cnt_reg;
      if (rx_push && !rx_pop) rx_cnt_next = rx_cnt_reg + (FIFO_AW+1)'(1);
      else if (!rx_push && rx_pop) rx_cnt_next = rx_cnt_reg - (FIFO_AW+1)'(1);
      // A set event in the same cycle as a STATUS read wins over the clear.
      tx_ovf_next = (wr_tx && tx_full && !tx_pop) ? 1'b1 :
                    (rd_status ? 1'b0 : tx_ovf_reg);
      rx_ovr_next = ((rx_state_reg == RX_CAPTURE) && rx_full && !rx_pop) ? 1'b1 :
                    (rd_status ? 1'b0 : rx_ovr_reg);
      case (addr)
         A_RX:     rdata_next = rx_empty ? 8'h00 : rx_mem[rx_rptr_reg];
         A_STATUS: rdata_next = status;
         A_CTRL:   rdata_next = ctrl_rd;
         default:  rdata_next = 8'h00;
      endcase
   end

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         tx_state_reg <= TX_IDLE;
         rx_state_reg <= RX_IDLE;
         u_ss         <= 1'b0;
         u_rr         <= 1'b0;
      end else begin
         tx_state_reg <= tx_state_next;
         rx_state_reg <= rx_state_next;
         u_ss         <= ss_next;
         u_rr         <= rr_next;
      end
   end

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         busy_meta_reg  <= 1'b0;
         sbusy_reg      <= 1'b0;
         valid_meta_reg <= 1'b0;
         svalid_reg     <= 1'b0;
         tx_wptr_reg    <= '0;
         tx_rptr_reg    <= '0;
         rx_wptr_reg    <= '0;
         rx_rptr_reg    <= '0;
         tx_cnt_reg     <= '0;
         rx_cnt_reg     <= '0;
         tx_ovf_reg     <= 1'b0;
         rx_ovr_reg     <= 1'b0;
         u_data         <= 8'h00;
         rdata          <= 8'h00;
      end else begin
         busy_meta_reg  <= u_busy;
         sbusy_reg      <= busy_meta_reg;
         valid_meta_reg <= u_rec_valid;
         svalid_reg     <= valid_meta_reg;
         if (tx_push) tx_wptr_reg <= tx_wptr_reg + FIFO_AW'(1);
         if (tx_pop)  tx_rptr_reg <= tx_rptr_reg + FIFO_AW'(1);
         if (rx_push) rx_wptr_reg <= rx_wptr_reg + FIFO_AW'(1);
         if (rx_pop)  rx_rptr_reg <= rx_rptr_reg + FIFO_AW'(1);
         tx_cnt_reg     <= tx_cnt_next;
         rx_cnt_reg     <= rx_cnt_next;
         tx_ovf_reg     <= tx_ovf_next;
         rx_ovr_reg     <= rx_ovr_next;
         if (tx_pop) u_data <= tx_mem[tx_rptr_reg];
         if (re)     rdata  <= rdata_next;
      end
   end

   // FIFO storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge sclk) begin
      if (tx_push) tx_mem[tx_wptr_reg] <= wdata;
      if (rx_push) rx_mem[rx_wptr_reg] <= u_rec_data;
   end

`ifdef UART_CTRL_IRQ_EN
   logic [2:0] ctrl_reg;
   logic       irq_reg, irq_next;

   assign ctrl_rd  = {5'b0, ctrl_reg};
   assign irq_next = (ctrl_reg[0] & !rx_empty) |
                     (ctrl_reg[1] & tx_empty & !tx_active) |
                     (ctrl_reg[2] & (rx_ovr_reg | tx_ovf_reg));
   assign irq      = irq_reg;

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         ctrl_reg <= 3'b000;
         irq_reg  <= 1'b0;
      end else begin
         if (we && (addr == A_CTRL)) ctrl_reg <= wdata[2:0];
         irq_reg <= irq_next;
      end
   end
`else
   assign ctrl_rd = 8'h00;
   assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl - directed self-checking bench for uart_ctrl.
// Drives the CPU bus and plays the UART core by hand (busy, rec_valid),
// checking every observation against hand-computed values.
module tb_uart_ctrl;

   logic       sclk, reset;
   logic [1:0] addr;
   logic [7:0] wdata, rdata, u_data, u_rec_data;
   logic       we, re, irq, u_ss, u_busy, u_rec_valid, u_rr;

   int n_checks = 0;
   int n_fail   = 0;

   uart_ctrl #(.FIFO_AW(3)) dut (
      .sclk(sclk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
      .rdata(rdata), .irq(irq), .u_ss(u_ss), .u_data(u_data), .u_busy(u_busy),
      .u_rec_data(u_rec_data), .u_rec_valid(u_rec_valid), .u_rr(u_rr)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance to 1 ns after the next rising edge; inputs change and outputs
   // are sampled there.
   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      addr = a; wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      addr = a; re = 1'b1;
      tick();
      re = 1'b0;
      d = rdata;
   endtask

   // Core-side receive: raise valid, drop it when u_rr is seen, and report
   // the rise latency and the width of the u_rr pulse.
   task automatic rx_byte(input logic [7:0] d, output int lat, output int width);
      u_rec_data = d; u_rec_valid = 1'b1;
      lat = 0;
      while (!u_rr && lat < 20) begin tick(); lat++; end
      u_rec_valid = 1'b0;
      width = 0;
      while (u_rr && width < 6) begin tick(); width++; end
      repeat (4) tick();
   endtask

   task automatic wait_ss(input string tag);
      int i;
      i = 0;
      while (!u_ss && i < 30) begin tick(); i++; end
      check(tag, u_ss, 1'b1);
   endtask

   logic [7:0] rd;
   int lat, width;

   initial begin
      reset = 1'b0; we = 1'b0; re = 1'b0; addr = 2'd0; wdata = 8'h00;
      u_busy = 1'b0; u_rec_data = 8'h00; u_rec_valid = 1'b0;

      // Reset with random inputs toggling
      repeat (4) begin
         addr = 2'($urandom); wdata = 8'($urandom); we = 1'($urandom);
         re = 1'($urandom); u_busy = 1'($urandom);
         u_rec_data = 8'($urandom); u_rec_valid = 1'($urandom);
         tick();
      end
      check("rst_rdata", rdata, 8'h00);
      check("rst_irq", irq, 1'b0);
      check("rst_u_ss", u_ss, 1'b0);
      check("rst_u_data", u_data, 8'h00);
      check("rst_u_rr", u_rr, 1'b0);
      we = 1'b0; re = 1'b0; u_busy = 1'b0; u_rec_valid = 1'b0; u_rec_data = 8'h00;
      reset = 1'b1;
      repeat (3) tick();
      bus_read(2'd2, rd); check("rst_status", rd, 8'h06);

      // Ignored writes and TXDATA read
      bus_write(2'd1, 8'hFF);
      bus_write(2'd2, 8'hFF);
      bus_read(2'd2, rd); check("ign_wr_status", rd, 8'h06);
      bus_read(2'd0, rd); check("txdata_read", rd, 8'h00);

      // Single TX byte, cycle-exact strobe timing
      bus_write(2'd0, 8'h55);                 // now in N+1
      check("tx_ss_n1", u_ss, 1'b0);
      tick(); check("tx_ss_n2", u_ss, 1'b0);
      check("tx_u_data", u_data, 8'h55);
      tick(); check("tx_ss_n3", u_ss, 1'b1);
      tick(); check("tx_ss_n4", u_ss, 1'b1);
      tick(); check("tx_ss_n5", u_ss, 1'b0);
      bus_read(2'd2, rd); check("tx_status_active", rd, 8'h46);
      u_busy = 1'b1;
      repeat (20) tick();
      u_busy = 1'b0;
      begin
         int i;
         i = 0;
         rd = 8'h40;
         while (rd[6] && i < 20) begin bus_read(2'd2, rd); i++; end
      end
      check("tx_status_done", rd, 8'h06);
      check("tx_u_data_hold", u_data, 8'h55);

      // TX overflow: busy held high, first byte in flight, FIFO fills
      u_busy = 1'b1;
      for (int k = 0; k < 9; k++) bus_write(2'd0, 8'(k));
      bus_read(2'd2, rd); check("txovf_full_no_ovf", rd, 8'h45);
      bus_write(2'd0, 8'h09);
      bus_read(2'd2, rd); check("txovf_status_set", rd, 8'h65);
      bus_read(2'd2, rd); check("txovf_status_clr", rd, 8'h45);
      check("txovf_inflight", u_data, 8'h00);
      for (int k = 1; k < 9; k++) begin
         u_busy = 1'b0;
         wait_ss("txovf_ss_seen");
         check("txovf_byte", u_data, 8'(k));
         u_busy = 1'b1;
         repeat (4) tick();
      end
      u_busy = 1'b0;
      repeat (6) tick();
      bus_read(2'd2, rd); check("txovf_drained", rd, 8'h06);

      // Single RX byte
      rx_byte(8'hA3, lat, width);
      check("rx_rr_latency", lat, 4);
      check("rx_rr_width", width, 2);
      bus_read(2'd2, rd); check("rx_status_data", rd, 8'h02);
      bus_read(2'd1, rd); check("rx_data", rd, 8'hA3);
      bus_read(2'd2, rd); check("rx_status_empty", rd, 8'h06);
      bus_read(2'd1, rd); check("rx_read_empty", rd, 8'h00);

      // RX overrun and pointer wrap
      for (int k = 0; k < 9; k++) begin
         rx_byte(8'h10 + 8'(k), lat, width);
         check("rxovr_rr_width", width, 2);
      end
      bus_read(2'd2, rd); check("rxovr_status_set", rd, 8'h1A);
      for (int k = 0; k < 8; k++) begin
         bus_read(2'd1, rd); check("rxovr_data", rd, 8'h10 + 8'(k));
      end
      bus_read(2'd2, rd); check("rxovr_status_clr", rd, 8'h06);
      for (int k = 0; k < 3; k++) rx_byte(8'h20 + 8'(k), lat, width);
      for (int k = 0; k < 3; k++) begin
         bus_read(2'd1, rd); check("rxwrap_data", rd, 8'h20 + 8'(k));
      end
      bus_read(2'd2, rd); check("rxwrap_status", rd, 8'h06);

`ifdef UART_CTRL_IRQ_EN
      bus_write(2'd3, 8'h01);
      bus_read(2'd3, rd); check("ctrl_readback", rd, 8'h01);
      check("irq_idle", irq, 1'b0);
      rx_byte(8'h5A, lat, width);
      check("irq_rx_set", irq, 1'b1);
      bus_read(2'd1, rd); check("irq_rx_data", rd, 8'h5A);
      check("irq_r_plus1", irq, 1'b1);
      tick(); check("irq_r_plus2", irq, 1'b0);
      bus_write(2'd3, 8'h00);
`else
      bus_write(2'd3, 8'h07);
      bus_read(2'd3, rd); check("ctrl_absent", rd, 8'h00);
      rx_byte(8'h5A, lat, width);
      check("irq_tied_low", irq, 1'b0);
      bus_read(2'd1, rd); check("rx_data_noirq", rd, 8'h5A);
`endif

      // Asynchronous reset in the middle of a transfer
      bus_write(2'd0, 8'h3C);
      wait_ss("midrst_ss_seen");
      #2 reset = 1'b0;
      #1;
      check("midrst_u_ss", u_ss, 1'b0);
      check("midrst_u_data", u_data, 8'h00);
      tick();
      reset = 1'b1;
      repeat (3) tick();
      bus_read(2'd2, rd); check("midrst_status", rd, 8'h06);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
